seq_shl: RTL and testbench
==========================

# seq_shl

Sequential logical shift-left unit: the left-shift counterpart to the datapath's combinational logical shift-right component. It accepts an operand and shift amount with a start pulse and shifts one bit position per clock. It returns the zero-filled result with a done pulse and an optional overflow flag. It sits in the datapath wherever a left shift is needed at low area cost and multi-cycle latency is acceptable.

## Interface
- DATAWIDTH, 8, bit width of `a`, `sh_amt` and `d`
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-low reset; clears all state immediately, release is synchronous to Clk
- start  input  1  request; sampled at a rising Clk edge only when the state is IDLE or DONE
- a  input  DATAWIDTH  operand, latched with an accepted start
- sh_amt  input  DATAWIDTH  unsigned shift amount, latched with an accepted start
- d  output  DATAWIDTH  result; zeros fill from the LSB
- busy  output  1  high in SHIFT state
- done  output  1  one-cycle pulse, high in DONE state
- ovf  output  1  any 1 bit shifted out of the MSB during the operation

## Operation
- Internal registers:
  - work[DATAWIDTH-1:0]
  - cnt, wide enough to hold DATAWIDTH
  - sticky ovf_acc
  - state ∈ {IDLE, SHIFT, DONE}
- Reset values:
  - state=IDLE
  - d=0, busy=0, done=0, ovf=0
  - work=0, cnt=0, ovf_acc=0
- IDLE: if start=1, then work←a, cnt←min(sh_amt, DATAWIDTH), ovf_acc←0, state←SHIFT. Otherwise hold.
- SHIFT, cnt≠0: work←{work[DATAWIDTH-2:0],1'b0}, ovf_acc←ovf_acc|work[DATAWIDTH-1], cnt←cnt−1.
- SHIFT, cnt=0: d←work, ovf←ovf_acc, state←DONE.
- DONE:
  - done=1 for exactly this cycle.
  - If start=1, it is accepted as in IDLE and the next state is SHIFT (back-to-back operation).
  - Otherwise state←IDLE.
- start is ignored while in SHIFT; there is no queueing.
- Shift-amount saturation: any sh_amt ≥ DATAWIDTH is treated as DATAWIDTH, giving d=0. ovf=1 iff a≠0.
- d and ovf are updated only on entry to DONE. They hold their last values through IDLE and SHIFT.
- Reset asserted mid-operation aborts the operation and returns every output to its reset value. No done pulse is produced.

## Timing
- Let n = min(sh_amt, DATAWIDTH) and let start be sampled at edge E0.
- busy is high from E0 through edge E(n+1).
- d and ovf become valid, and done rises, after edge E(n+1). done falls after E(n+2).
- Latency from the start edge to done high is n+1 cycles:
  - sh_amt=0 → 1 cycle
  - DATAWIDTH=8, sh_amt≥8 → 9 cycles
- Peak throughput is one operation every n+2 cycles using back-to-back start in DONE.

## Configuration
- SEQ_SHL_OVF_EN defined: ovf_acc logic is built and ovf behaves as described.
- SEQ_SHL_OVF_EN undefined: the ovf port remains present but is tied to 0. No ovf_acc register is built, and all other behaviour is unchanged.

## Test plan
- Reset: hold Rst=0 with random inputs and toggling start → d=0, busy=0, done=0, ovf=0 throughout. After release with start=0 → outputs stay at 0.
- Basic shift: start, a=8'h0F, sh_amt=4 → busy for 5 cycles, then done 5 cycles after the start edge with d=8'hF0 and ovf=0. d holds 8'hF0 afterwards.
- Overflow and zero shift:
  - a=8'h81, sh_amt=1 → d=8'h02, ovf=1, done after 2 cycles.
  - Then a=8'hA5, sh_amt=0 → d=8'hA5, ovf=0, done after 1 cycle.
- Saturation: a=8'h01, sh_amt=8'd200 → d=8'h00, ovf=1, done 9 cycles after start. With a=8'h00 → ovf=0.
- Busy rejection and back-to-back:
  - a=8'h03, sh_amt=2 is running.
  - Pulse start with a=8'hFF in SHIFT → ignored, result d=8'h0C.
  - Start asserted during the DONE cycle with a=8'h01, sh_amt=3 → accepted, d=8'h08 after 4 more cycles.
- Reset mid-operation: a=8'h55, sh_amt=6, assert Rst at cycle 3 → outputs go to 0 immediately and no done pulse occurs. After release, a fresh start with a=8'h55, sh_amt=1 → d=8'hAA.

Source files
------------

// File: rtl/seq_shl.sv
// seq_shl: sequential logical shift-left, one bit position per clock.
// An accepted start latches a and a saturated shift amount, then shifts until
// the count reaches zero, then presents d/ovf with a one-cycle done pulse.
// Optional feature macro: SEQ_SHL_OVF_EN builds the overflow accumulator;
// without it, ovf is tied to 0.
module seq_shl #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] sh_amt,
    output logic [DATAWIDTH-1:0] d,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam int unsigned          CW      = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0]        CNT_MAX = CW'(DATAWIDTH);
    localparam logic [DATAWIDTH-1:0] AMT_MAX = DATAWIDTH'(DATAWIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [DATAWIDTH-1:0]   work;
    logic [CW-1:0]          cnt;
    logic                   accept;
    logic [CW-1:0]          cnt_load;

    // start is only honoured when no operation is in flight
    always_comb begin
        accept   = start && ((state == IDLE) || (state == DONE));
        cnt_load = (sh_amt >= AMT_MAX) ? CNT_MAX : sh_amt[CW-1:0];
    end

    // state register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? SHIFT : IDLE;
            SHIFT:   state_nxt = (cnt == '0) ? DONE : SHIFT;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // status outputs decoded from state
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // operand load, per-cycle shift, and result capture on entry to DONE
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            work <= '0;
            cnt  <= '0;
            d    <= '0;
        end else if (accept) begin
            work <= a;
            cnt  <= cnt_load;
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                work <= {work[DATAWIDTH-2:0], 1'b0};
                cnt  <= cnt - CW'(1);
            end else begin
                d    <= work;
            end
        end
    end

`ifdef SEQ_SHL_OVF_EN
    logic ovf_acc;

    // sticky record of any 1 shifted out of the MSB, published with d
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ovf_acc <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            ovf_acc <= 1'b0;
        end else if (state == SHIFT) begin
            if (cnt != '0) ovf_acc <= ovf_acc | work[DATAWIDTH-1];
            else           ovf     <= ovf_acc;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_shl.sv
// Directed testbench for seq_shl (DATAWIDTH = 8) with hand-computed results.
// Expected ovf values are gated by SEQ_SHL_OVF_EN to match the build.
module tb_seq_shl;

`ifdef SEQ_SHL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       Clk;
    logic       Rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] sh_amt;
    logic [7:0] d;
    logic       busy;
    logic       done;
    logic       ovf;

    int n_chk  = 0;
    int n_pass = 0;

    seq_shl #(.DATAWIDTH(8)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .start  (start),
        .a      (a),
        .sh_amt (sh_amt),
        .d      (d),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // present an operation and clock it in; returns 1 time unit after the start edge
    task automatic start_op(input logic [7:0] av, input logic [7:0] amt);
        start  = 1'b1;
        a      = av;
        sh_amt = amt;
        @(posedge Clk); #1;
        start  = 1'b0;
    endtask

    // wait for done (bounded); cyc0 = edges already elapsed since the start edge
    task automatic finish_op(input string tag, input int cyc0, input int lat,
                             input logic [7:0] ed, input logic eo);
        int cyc;
        int busyn;
        cyc   = cyc0;
        busyn = cyc0;
        if (busy) busyn++;
        while (!done && cyc < 30) begin
            @(posedge Clk); #1;
            cyc++;
            if (busy) busyn++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " busy cycles"}, 32'(busyn), 32'(lat));
        check({tag, " d"}, 32'(d), 32'(ed));
        check({tag, " ovf"}, 32'(ovf), 32'(eo & OVF_EN));
    endtask

    // one idle cycle after DONE: pulse must end and the result must hold
    task automatic post_idle(input string tag, input logic [7:0] ed);
        @(posedge Clk); #1;
        check({tag, " done low"}, 32'(done), 32'(0));
        check({tag, " busy low"}, 32'(busy), 32'(0));
        check({tag, " d hold"}, 32'(d), 32'(ed));
    endtask

    initial begin
        Rst    = 1'b0;
        start  = 1'b0;
        a      = '0;
        sh_amt = '0;

        // reset held with random activity on the inputs
        for (int i = 0; i < 6; i++) begin
            start  = i[0];
            a      = 8'($urandom);
            sh_amt = 8'($urandom);
            @(posedge Clk); #1;
            check("reset outs", 32'({d, busy, done, ovf}), 32'(0));
        end
        start = 1'b0;
        #3 Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            check("post-reset outs", 32'({d, busy, done, ovf}), 32'(0));
        end

        // basic shift
        start_op(8'h0F, 8'd4);
        finish_op("basic", 0, 5, 8'hF0, 1'b0);
        post_idle("basic", 8'hF0);

        // overflow, then zero shift (d holds while the next op is in SHIFT)
        start_op(8'h81, 8'd1);
        finish_op("ovf", 0, 2, 8'h02, 1'b1);
        post_idle("ovf", 8'h02);
        start_op(8'hA5, 8'd0);
        check("zero d hold in shift", 32'(d), 32'(8'h02));
        finish_op("zero", 0, 1, 8'hA5, 1'b0);
        post_idle("zero", 8'hA5);

        // saturated shift amount
        start_op(8'h01, 8'd200);
        finish_op("sat1", 0, 9, 8'h00, 1'b1);
        post_idle("sat1", 8'h00);
        start_op(8'h00, 8'd200);
        finish_op("sat0", 0, 9, 8'h00, 1'b0);
        post_idle("sat0", 8'h00);

        // start ignored in SHIFT, then back-to-back start during DONE
        start_op(8'h03, 8'd2);
        start  = 1'b1;
        a      = 8'hFF;
        sh_amt = 8'd7;
        @(posedge Clk); #1;
        start  = 1'b0;
        finish_op("reject", 1, 3, 8'h0C, 1'b0);
        start_op(8'h01, 8'd3);
        check("b2b busy after done", 32'(busy), 32'(1));
        finish_op("b2b", 0, 4, 8'h08, 1'b0);
        post_idle("b2b", 8'h08);

        // reset mid-operation
        start_op(8'h55, 8'd6);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        #1;
        check("abort outs", 32'({d, busy, done, ovf}), 32'(0));
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            if (i == 7) check("abort no done", 32'({d, busy, done, ovf}), 32'(0));
        end
        #2 Rst = 1'b1;
        @(posedge Clk); #1;
        check("abort idle", 32'({d, busy, done, ovf}), 32'(0));
        start_op(8'h55, 8'd1);
        finish_op("restart", 0, 2, 8'hAA, 1'b0);
        post_idle("restart", 8'hAA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
